serial_bus_master_port: RTL
===========================

// Module: serial_bus_master_port
// PURPOSE
// Master-side serial port of the single-wire bus. Accepts one parallel read/write request, requests the slave
// by pulling its line low, waits for the slave's ready (low) reply, then shifts 12-bit address, mode bit
// and 8-bit write data out LSB-first, or shifts 8 read-data bits in. Sits directly upstream of a bus slave:
// bus_tx drives the slave rx pin, bus_rx is the slave tx pin. One clock domain, one outstanding transaction.
// PARAMETERS
// ADDR_W   12    address bits shifted, LSB first
// DATA_W   8     data bits shifted, LSB first
// GUARD    4     cycles the slave holds ready before sampling address bit 0
// TIMEOUT  1024  max cycles in REQ (slave busy/split) before abort with error
// PORTS
// clk        in   1       clock
// rstn       in   1       async active-low reset
// req_valid  in   1       request present
// req_ready  out  1       port can accept; high only in IDLE
// req_write  in   1       1 = write to slave, 0 = read from slave
// req_addr   in   ADDR_W  slave address
// req_wdata  in   DATA_W  write data
// rsp_valid  out  1       one-cycle completion pulse, no backpressure
// rsp_rdata  out  DATA_W  read data, valid with rsp_valid (0 on write/error)
// rsp_err    out  1       timeout flag, valid with rsp_valid
// bus_tx     out  1       serial line to slave rx; idle high
// bus_rx     in   1       serial line from slave tx; idle high, same clock domain, no synchroniser
// state_o    out  4       current FSM state (debug)
// BEHAVIOUR
// - Reset (async): state IDLE, bus_tx=1, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; internal counters 0.
//   Reset mid-transaction abandons it; bus_tx returns high immediately, no rsp_valid is generated.
// - All outputs registered. Accept at edge ending cycle A when req_valid&&req_ready; capture write/addr/wdata.
// - FSM: IDLE->REQ->GUARD->ADDR->MODE->(WDATA|RDATA)->DONE->IDLE; REQ->DONE on timeout.
// - REQ: bus_tx=0 from cycle A+1. Ready = bus_rx sampled 0 in REQ; first such cycle is R. Count REQ cycles;
//   if count reaches TIMEOUT with no ready -> DONE with err=1, bus_tx=1. Split (slave busy) needs no special
//   handling: line stays low until slave replies. Non-busy slave gives R = A+3.
// - GUARD: bus_tx=1 during cycles R+1..R+GUARD-1.
// - ADDR: bus_tx=addr[i] during cycle R+GUARD+i, i=0..ADDR_W-1 (defaults: R+4..R+15).
// - MODE: bus_tx=write during cycle R+GUARD+ADDR_W (R+16).
// - WDATA: bus_tx=wdata[j] during R+17+j, j=0..7; bus_tx=1 from R+25.
// - RDATA: bus_tx=1 from R+17; rdata[j] <= bus_rx sampled in cycle R+18+j, j=0..7.
// - DONE: rsp_valid=1 in cycle R+26 for both read and write (slave back in IDLE); rsp_rdata/rsp_err held
//   until next rsp_valid. IDLE re-entered R+27; req_ready=1 there, so bus_tx high >=2 cycles between requests.
// - bus_rx activity outside REQ/RDATA ignored. bus_rx low already when REQ entered counts as ready (R=A+1).
// - Counters sized for max(ADDR_W,TIMEOUT); no wrap within a transaction.
// TESTING
// 1 write addr=0x123 wdata=0xA5, idle slave model -> bus_tx 0 at A+1..A+3, addr bits 1,1,0,0,0,1,0,0,1,0,0,0
//   at R+4..R+15, 1 at R+16, 1,0,1,0,0,1,0,1 at R+17..R+24; rsp_valid at R+26, err=0.
// 2 read addr=0x0FF, slave returns 0xD3 -> mode bit 0 at R+16; rsp_valid at R+26, rsp_rdata=0xD3, err=0.
// 3 slave busy 20 cycles (split) -> bus_tx held low throughout; ready at R, all later offsets relative to R.
// 4 TIMEOUT=16, bus_rx held high -> rsp_valid at A+17, rsp_err=1, rsp_rdata=0, bus_tx=1 from A+17.
// 5 rstn low during ADDR phase -> bus_tx=1, rsp_valid=0 immediately; after release req_ready=1, next write ok.
// 6 req_valid held for two reads (0xD3, then 0x3C) -> second accepted at R1+27, both responses correct.

Source files
------------

// File: rtl/serial_bus_master_port.sv
// Master side of the single-wire serial bus: requests the slave, waits for its ready reply,
// then shifts address, mode and write data out (or read data in), all LSB first.
module serial_bus_master_port #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int GUARD   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_bus_tx,
  input  logic              i_bus_rx,
  output logic [3:0]        o_state
);

  localparam int CNT_MAX = (ADDR_W > TIMEOUT) ? ADDR_W : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_REQ   = 4'd1,
    S_GUARD = 4'd2,
    S_ADDR  = 4'd3,
    S_MODE  = 4'd4,
    S_WDATA = 4'd5,
    S_RDATA = 4'd6,
    S_DONE  = 4'd7
  } state_t;

  state_t              r_state, w_state_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic                r_write, w_write_next;
  logic [ADDR_W-1:0]   r_addr, w_addr_next;
  logic [DATA_W-1:0]   r_data, w_data_next;
  logic                r_bus_tx, w_bus_tx_next;
  logic                r_req_ready, w_req_ready_next;
  logic                r_rsp_valid, w_rsp_valid_next;
  logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_next;
  logic                r_rsp_err, w_rsp_err_next;

  // Every output is registered, so bus_tx is computed one cycle ahead of the phase it belongs to.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_write_next     = r_write;
    w_addr_next      = r_addr;
    w_data_next      = r_data;
    w_bus_tx_next    = 1'b1;
    w_rsp_valid_next = 1'b0;
    w_rsp_rdata_next = r_rsp_rdata;
    w_rsp_err_next   = r_rsp_err;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_state_next  = S_REQ;
          w_cnt_next    = '0;
          w_write_next  = i_req_write;
          w_addr_next   = i_req_addr;
          w_data_next   = i_req_wdata;
          w_bus_tx_next = 1'b0;
        end
      end
      S_REQ: begin
        if (!i_bus_rx) begin
          w_state_next = S_GUARD;
          w_cnt_next   = '0;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_state_next     = S_DONE;
          w_rsp_valid_next = 1'b1;
          w_rsp_rdata_next = '0;
          w_rsp_err_next   = 1'b1;
        end else begin
          w_cnt_next    = r_cnt + 1'b1;
          w_bus_tx_next = 1'b0;
        end
      end
      S_GUARD: begin
        if (r_cnt == CNT_W'(GUARD - 2)) begin
          w_state_next  = S_ADDR;
          w_cnt_next    = '0;
          w_bus_tx_next = r_addr[0];
          w_addr_next   = r_addr >> 1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_ADDR: begin
        if (r_cnt == CNT_W'(ADDR_W - 1)) begin
          w_state_next  = S_MODE;
          w_bus_tx_next = r_write;
        end else begin
          w_cnt_next    = r_cnt + 1'b1;
          w_bus_tx_next = r_addr[0];
          w_addr_next   = r_addr >> 1;
        end
      end
      S_MODE: begin
        w_cnt_next = '0;
        if (r_write) begin
          w_state_next  = S_WDATA;
          w_bus_tx_next = r_data[0];
          w_data_next   = r_data >> 1;
        end else begin
          w_state_next = S_RDATA;
        end
      end
      S_WDATA: begin
        // One extra idle-high bit time after the last data bit lets the slave return to idle.
        if (r_cnt == CNT_W'(DATA_W)) begin
          w_state_next     = S_DONE;
          w_rsp_valid_next = 1'b1;
          w_rsp_rdata_next = '0;
          w_rsp_err_next   = 1'b0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
          if (r_cnt != CNT_W'(DATA_W - 1)) begin
            w_bus_tx_next = r_data[0];
            w_data_next   = r_data >> 1;
          end
        end
      end
      S_RDATA: begin
        // The slave's first data bit arrives one cycle after the turnaround cycle.
        if (r_cnt == CNT_W'(DATA_W)) begin
          w_state_next     = S_DONE;
          w_rsp_valid_next = 1'b1;
          w_rsp_rdata_next = {i_bus_rx, r_data[DATA_W-1:1]};
          w_rsp_err_next   = 1'b0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
          if (r_cnt != '0) w_data_next = {i_bus_rx, r_data[DATA_W-1:1]};
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    w_req_ready_next = (w_state_next == S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_bus_tx    <= 1'b1;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_write     <= w_write_next;
      r_addr      <= w_addr_next;
      r_data      <= w_data_next;
      r_bus_tx    <= w_bus_tx_next;
      r_req_ready <= w_req_ready_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_rsp_err   <= w_rsp_err_next;
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_bus_tx    = r_bus_tx;
  assign o_state     = r_state;

endmodule
